// File: rtl/bus_pkg.sv
// Shared definitions for the round-robin bus arbiter.
// Optional build macro: BUS_TURNAROUND_EN (inserts a dead cycle between bus owners).
package bus_pkg;

  localparam int unsigned BusNReq = 4;
  localparam int unsigned BusIdW  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  // Next index around a ring of n entries.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin search: first candidate at or after ptr_i, wrapping around,
// ignoring requesters flagged in excl_i.
module rr_pick #(
  parameter int unsigned N_REQ = bus_pkg::BusNReq,
  parameter int unsigned ID_W  = bus_pkg::BusIdW
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  input  logic [N_REQ-1:0] excl_i,
  output logic [N_REQ-1:0] pick_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             found_o
);

  logic [N_REQ-1:0] cand;
  assign cand = req_i & ~excl_i;

  always_comb begin
    int unsigned      j;
    logic [N_REQ-1:0] bit_mask;
    j        = 0;
    bit_mask = '0;
    pick_o   = '0;
    idx_o    = '0;
    found_o  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j        = (32'(ptr_i) + i) % N_REQ;
      bit_mask = N_REQ'(1) << j;
      if (!found_o && |(cand & bit_mask)) begin
        found_o = 1'b1;
        pick_o  = bit_mask;
        idx_o   = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter producing registered one-hot enables for the tri-state bus banks.
// Optional build macro: BUS_TURNAROUND_EN adds a one-cycle TURN gap between owners.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned N_REQ    = BusNReq,
  parameter int unsigned ID_W     = BusIdW,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             expired
);

  localparam int unsigned HcntW    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned HoldLast = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [HcntW-1:0] HcntLast = HcntW'(HoldLast);

  arb_state_e       state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [ID_W-1:0]  gnt_id_q;
  logic             busy_q;
  logic             expired_q;
  logic [ID_W-1:0]  ptr_q;
  logic [HcntW-1:0] hcnt_q;

  logic             owner_req;
  logic             at_limit;
  logic             release_grant;
  logic             revoked;
  logic [ID_W-1:0]  next_ptr;
  logic [ID_W-1:0]  pick_ptr;
  logic [N_REQ-1:0] pick_excl;
  logic [N_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_found;

  assign owner_req     = |(req & gnt_q);
  assign at_limit      = (MAX_HOLD != 0) && (hcnt_q == HcntLast);
  assign release_grant = !owner_req || at_limit;
  // Only a grant taken away from a still-requesting owner counts as expiry.
  assign revoked       = owner_req && at_limit;
  assign next_ptr      = ID_W'(wrap_inc(32'(gnt_id_q), N_REQ));

  // While granted, search from the owner's successor with the owner masked off, so a
  // still-requesting expired owner only gets the bus back when nobody else wants it.
  always_comb begin
    pick_ptr  = ptr_q;
    pick_excl = '0;
    if (state_q == GRANT) begin
      pick_ptr  = next_ptr;
      pick_excl = gnt_q;
    end
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (pick_ptr),
    .excl_i  (pick_excl),
    .pick_o  (pick_gnt),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
      ptr_q     <= '0;
      hcnt_q    <= '0;
    end else begin
      expired_q <= 1'b0;
      case (state_q)
        IDLE, TURN: begin
          hcnt_q <= '0;
          if (pick_found) begin
            state_q  <= GRANT;
            gnt_q    <= pick_gnt;
            gnt_id_q <= pick_idx;
            busy_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        GRANT: begin
          if (!release_grant) begin
            hcnt_q <= hcnt_q + 1'b1;
          end else begin
            ptr_q     <= next_ptr;
            expired_q <= revoked;
            hcnt_q    <= '0;
`ifdef BUS_TURNAROUND_EN
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= (pick_found || revoked) ? TURN : IDLE;
`else
            if (pick_found) begin
              gnt_q    <= pick_gnt;
              gnt_id_q <= pick_idx;
            end else if (!revoked) begin
              state_q <= IDLE;
              gnt_q   <= '0;
              busy_q  <= 1'b0;
            end
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed vectors on MAX_HOLD=16/4 instances,
// random contention on MAX_HOLD=0/5 instances.
module tb_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rst_r;
  logic [3:0] req_a, req_b, req_r;
  logic [3:0] gnt_a, gnt_b, gnt_c, gnt_d;
  logic [1:0] id_a, id_b, id_c, id_d;
  logic       busy_a, busy_b, busy_c, busy_d;
  logic       exp_a, exp_b, exp_c, exp_d;

  bus_arbiter #(.N_REQ(4), .ID_W(2), .MAX_HOLD(16)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .gnt(gnt_a), .gnt_id(id_a), .busy(busy_a),
    .expired(exp_a)
  );
  bus_arbiter #(.N_REQ(4), .ID_W(2), .MAX_HOLD(4)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .gnt(gnt_b), .gnt_id(id_b), .busy(busy_b),
    .expired(exp_b)
  );
  bus_arbiter #(.N_REQ(4), .ID_W(2), .MAX_HOLD(0)) dut_c (
    .clk(clk), .rst(rst_r), .req(req_r), .gnt(gnt_c), .gnt_id(id_c), .busy(busy_c),
    .expired(exp_c)
  );
  bus_arbiter #(.N_REQ(4), .ID_W(2), .MAX_HOLD(5)) dut_d (
    .clk(clk), .rst(rst_r), .req(req_r), .gnt(gnt_d), .gnt_id(id_d), .busy(busy_d),
    .expired(exp_d)
  );

`ifdef BUS_TURNAROUND_EN
  localparam int unsigned WaitBound = 3 * 5 + 3;
`else
  localparam int unsigned WaitBound = 3 * 5;
`endif

  typedef struct {
    int unsigned dut;
    logic [3:0]  gnt;
    logic [1:0]  id;
    logic        busy;
    logic        exp;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic        rnd_on      = 1'b0;
  logic        rand_done   = 1'b0;
  int unsigned wait_cnt [4];

  // Apply inputs for one edge; the expected post-edge outputs go to the scoreboard.
  task automatic step(input int unsigned d, input logic r, input logic [3:0] rq,
                      input logic [3:0] eg, input int unsigned eid, input logic eb,
                      input logic ee, input string nm);
    exp_t e;
    if (d == 0) begin
      rst_a = r;
      req_a = rq;
    end else begin
      rst_b = r;
      req_b = rq;
    end
    @(posedge clk);
    e.dut  = d;
    e.gnt  = eg;
    e.id   = 2'(eid);
    e.busy = eb;
    e.exp  = ee;
    sb_q.push_back(e);
    nm_q.push_back(nm);
    #1;
  endtask

  // Monitor: pops the scoreboard and runs the contention checks, all at the falling edge.
  always @(negedge clk) begin
    exp_t       e;
    string      nm;
    logic [3:0] g;
    logic [1:0] id;
    logic       b, x;
    if (sb_q.size() != 0) begin
      e  = sb_q.pop_front();
      nm = nm_q.pop_front();
      if (e.dut == 0) begin
        g = gnt_a; id = id_a; b = busy_a; x = exp_a;
      end else begin
        g = gnt_b; id = id_b; b = busy_b; x = exp_b;
      end
      vectors++;
      if (g !== e.gnt || b !== e.busy || x !== e.exp || (e.busy && id !== e.id)) begin
        miscompares++;
        $display("FAIL %s @%0t: got gnt=%b id=%0d busy=%b expired=%b, want gnt=%b id=%0d busy=%b expired=%b",
                 nm, $time, g, id, b, x, e.gnt, e.id, e.busy, e.exp);
      end
    end
    if (rnd_on) begin
      vectors++;
      if (!$onehot0(gnt_c)) begin
        miscompares++;
        $display("FAIL onehot_hold0 @%0t: gnt=%b, want one-hot or zero", $time, gnt_c);
      end
      vectors++;
      if (!$onehot0(gnt_d)) begin
        miscompares++;
        $display("FAIL onehot_hold5 @%0t: gnt=%b, want one-hot or zero", $time, gnt_d);
      end
      for (int m = 0; m < 4; m++) begin
        if (req_r[m] && !gnt_d[m]) wait_cnt[m]++;
        else wait_cnt[m] = 0;
        vectors++;
        if (wait_cnt[m] > WaitBound) begin
          miscompares++;
          $display("FAIL wait_master%0d @%0t: waited %0d cycles, want <= %0d",
                   m, $time, wait_cnt[m], WaitBound);
          wait_cnt[m] = 0;
        end
      end
    end
  end

  // Random contention driver, changes req half a cycle away from the sampling edge.
  initial begin
    for (int m = 0; m < 4; m++) wait_cnt[m] = 0;
    rst_r = 1'b1;
    req_r = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    rst_r  = 1'b0;
    rnd_on = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(7) == 0) req_r[k] = ~req_r[k];
      end
    end
    rand_done = 1'b1;
  end

  initial begin
    logic [3:0] drop;
    logic [3:0] nxt_oh;
    rst_a = 1'b1; req_a = 4'b0000;
    rst_b = 1'b1; req_b = 4'b0000;
    @(posedge clk);
    #1;

    // Reset holds the bus off even with everyone requesting.
    step(0, 1, 4'b1111, 4'b0000, 0, 0, 0, "rst_hold0");
    step(0, 1, 4'b1111, 4'b0000, 0, 0, 0, "rst_hold1");
    step(0, 0, 4'b0100, 4'b0100, 2, 1, 0, "rst_release");
    step(0, 0, 4'b0000, 4'b0000, 0, 0, 0, "idle_return");

    // Rotation 0,1,2,3,0 with each owner dropping req for one cycle.
    step(0, 1, 4'b0000, 4'b0000, 0, 0, 0, "rot_rst");
    step(0, 0, 4'b1111, 4'b0001, 0, 1, 0, "rot_first");
    for (int i = 1; i <= 4; i++) begin
      drop   = 4'b1111 & ~(4'b0001 << ((i - 1) % 4));
      nxt_oh = 4'b0001 << (i % 4);
`ifdef BUS_TURNAROUND_EN
      step(0, 0, drop, 4'b0000, 0, 0, 0, "rot_turn");
      step(0, 0, 4'b1111, nxt_oh, i % 4, 1, 0, "rot_next");
`else
      step(0, 0, drop, nxt_oh, i % 4, 1, 0, "rot_next");
`endif
    end
    step(0, 0, 4'b0000, 4'b0000, 0, 0, 0, "rot_idle");

    // Master 0 holds with master 1 waiting: 16 granted cycles, then expiry handoff.
    step(0, 1, 4'b0000, 4'b0000, 0, 0, 0, "exp_rst");
    for (int i = 0; i < 16; i++) step(0, 0, 4'b0011, 4'b0001, 0, 1, 0, "exp_hold");
`ifdef BUS_TURNAROUND_EN
    step(0, 0, 4'b0011, 4'b0000, 0, 0, 1, "exp_turn");
    step(0, 0, 4'b0011, 4'b0010, 1, 1, 0, "exp_next");
`else
    step(0, 0, 4'b0011, 4'b0010, 1, 1, 1, "exp_handoff");
    step(0, 0, 4'b0011, 4'b0010, 1, 1, 0, "exp_after");
`endif
    step(0, 0, 4'b0000, 4'b0000, 0, 0, 0, "exp_idle");

    // Reset in the middle of a grant to master 3; pointer returns to 0.
    step(0, 0, 4'b1000, 4'b1000, 3, 1, 0, "mid_grant3");
    step(0, 0, 4'b1000, 4'b1000, 3, 1, 0, "mid_hold3");
    step(0, 1, 4'b1000, 4'b0000, 0, 0, 0, "mid_rst");
    step(0, 0, 4'b1001, 4'b0001, 0, 1, 0, "mid_ptr0");
    step(0, 0, 4'b0000, 4'b0000, 0, 0, 0, "mid_idle");

    // Lone requester with MAX_HOLD=4 keeps the bus, expiring every 4 cycles.
    step(1, 1, 4'b0000, 4'b0000, 0, 0, 0, "lone_rst");
    for (int i = 1; i <= 12; i++) begin
`ifdef BUS_TURNAROUND_EN
      if (i % 5 == 0) step(1, 0, 4'b0001, 4'b0000, 0, 0, 1, "lone_turn");
      else            step(1, 0, 4'b0001, 4'b0001, 0, 1, 0, "lone_hold");
`else
      step(1, 0, 4'b0001, 4'b0001, 0, 1, (i % 4 == 1) && (i > 1), "lone_hold");
`endif
    end
    step(1, 0, 4'b0000, 4'b0000, 0, 0, 0, "lone_idle");

    wait (rand_done);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
